// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM states, memory bus codes and access-size codes shared with cache and cpu
package mem_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, INST_RD, DATA_RD, DATA_WR, DONE} arb_state_t;
    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] REQ_READ  = 2'b01;
    localparam logic [1:0] REQ_WRITE = 2'b10;
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        return size == SIZE_BYTE ? 3'd1 : size == SIZE_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: byte counter, address stepping, write lane select and read assembly
module mem_byte_seq #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  run,
    input  logic [2:0]            nbytes,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN-1:0]        wdata,
    input  logic [BYTE_SIZE-1:0]  mem_data,
    output logic [2:0]            cnt,
    output logic                  issue,
    output logic [ADDR_WIDTH-1:0] vis_addr,
    output logic [BYTE_SIZE-1:0]  wbyte,
    output logic [LEN-1:0]        rdata
);
    logic [ADDR_WIDTH-1:0] base;
    logic [LEN-1:0]        wd;
    logic [LEN-1:0]        rbuf;
    logic [1:0]            lane;
    logic                  capture;
    assign issue   = run && cnt < nbytes;
    assign capture = run && cnt >= 3'd2 && cnt <= nbytes + 3'd1;
    assign lane    = 2'(cnt - 3'd2);
    assign rdata   = rbuf | (capture ? LEN'(mem_data) << (BYTE_SIZE * int'(lane)) : '0);
    // latch on grant, then each cycle drive byte cnt onto the bus and merge the byte issued two cycles earlier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 3'd0;
            base     <= '0;
            wd       <= '0;
            rbuf     <= '0;
            vis_addr <= '0;
            wbyte    <= '0;
        end else if (load) begin
            cnt  <= 3'd0;
            base <= addr;
            wd   <= wdata;
            rbuf <= '0;
        end else if (run) begin
            cnt <= cnt + 3'd1;
            if (issue) begin
                vis_addr <= base + ADDR_WIDTH'(cnt);
                wbyte    <= wd[BYTE_SIZE * int'(cnt[1:0]) +: BYTE_SIZE];
            end
            if (capture) rbuf <= rdata;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: instruction/data arbitration onto a byte-wide memory bus; MEM_ARB_RR_EN enables alternating grants
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [LEN-1:0]        inst_data,
    output logic                  inst_done,
    input  logic [1:0]            data_req,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [LEN-1:0]        data_wdata,
    output logic [LEN-1:0]        data_rdata,
    output logic                  data_done,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [1:0]            mem_vis_signal,
    output logic [BYTE_SIZE-1:0]  writen_data,
    input  logic [BYTE_SIZE-1:0]  mem_data
);
    arb_state_t     state, state_next;
    logic           data_vld, grant, grant_data, run, issue, own_data;
    logic [2:0]     nbytes, cnt;
    logic [LEN-1:0] result;
    assign data_vld = data_req == REQ_READ || data_req == REQ_WRITE;
    assign grant    = state == IDLE && (inst_req || data_vld);
    assign run      = state == INST_RD || state == DATA_RD || state == DATA_WR;
`ifdef MEM_ARB_RR_EN
    logic last_data;
    assign grant_data = data_vld && !(inst_req && last_data);
    // remember who won the latest grant so a tie goes to the other requester
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_data <= 1'b0;
        else if (grant) last_data <= grant_data;
    end
`else
    assign grant_data = data_vld;
`endif
    // leave IDLE on the grant edge; reads end once the last byte is captured, writes once it is on the bus
    always_comb begin
        state_next = state;
        case (state)
            IDLE:             state_next = !grant ? IDLE : !grant_data ? INST_RD :
                                           data_req == REQ_WRITE ? DATA_WR : DATA_RD;
            INST_RD, DATA_RD: state_next = cnt == nbytes + 3'd1 ? DONE : state;
            DATA_WR:          state_next = cnt == nbytes ? DONE : state;
            default:          state_next = IDLE;
        endcase
    end
    // state, owner and length of the granted access, registered bus command and per-port results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            own_data       <= 1'b0;
            nbytes         <= 3'd0;
            mem_vis_signal <= MEM_IDLE;
            inst_data      <= '0;
            data_rdata     <= '0;
        end else begin
            state          <= state_next;
            mem_vis_signal <= !issue ? MEM_IDLE : state == DATA_WR ? MEM_WRITE : MEM_READ;
            if (grant) begin
                own_data <= grant_data;
                nbytes   <= grant_data ? byte_count(data_size) : 3'd4;
            end
            if (state_next == DONE && state != DATA_WR) begin
                if (own_data) data_rdata <= result;
                else inst_data <= result;
            end
        end
    end
    assign inst_done = state == DONE && !own_data;
    assign data_done = state == DONE && own_data;
    mem_byte_seq #(
        .LEN(LEN),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYTE_SIZE(BYTE_SIZE)
    ) u_seq (
        .clk(clk),
        .rst(rst),
        .load(grant),
        .run(run),
        .nbytes(nbytes),
        .addr(grant_data ? data_addr : inst_addr),
        .wdata(data_wdata),
        .mem_data(mem_data),
        .cnt(cnt),
        .issue(issue),
        .vis_addr(mem_vis_addr),
        .wbyte(writen_data),
        .rdata(result)
    );
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: LEN default 32 (word width); ADDR_WIDTH default 17 (byte address width); BYTE_SIZE default 8.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- inst_req  in  1  instruction word read request
- inst_addr  in  ADDR_WIDTH  instruction byte address
- inst_data  out  LEN  fetched instruction
- inst_done  out  1  one-cycle completion pulse
- data_req  in  2  00 none, 01 read, 10 write, 11 reserved (treated as none)
- data_size  in  2  00 byte, 01 half, 10 word
- data_addr  in  ADDR_WIDTH  data byte address
- data_wdata  in  LEN  write data, little-endian
- data_rdata  out  LEN  read data, zero-extended
- data_done  out  1  one-cycle completion pulse
- mem_vis_addr  out  ADDR_WIDTH  main-memory byte address
- mem_vis_signal  out  2  00 idle, 01 read, 10 write
- writen_data  out  BYTE_SIZE  byte to write
- mem_data  in  BYTE_SIZE  byte read, valid one cycle after the read issue

Function
REQ-003 The FSM SHALL have states IDLE, INST_RD, DATA_RD, DATA_WR and DONE.
REQ-004 In IDLE, requests SHALL be sampled at each edge; the winner's address, size, write data and identity SHALL be latched, and the FSM SHALL leave IDLE on the same edge.
REQ-005 Byte count SHALL be: 4 for instruction reads; 1, 2 or 4 for data per data_size.
REQ-006 Byte k SHALL be issued on the k-th cycle after the grant, with mem_vis_addr = latched addr + k modulo 2^ADDR_WIDTH; no alignment check SHALL be applied.
REQ-007 Reads: mem_data captured in the cycle after issue k SHALL land in result bits [8k+7:8k]; upper unused bytes SHALL be 0.
REQ-008 Writes: writen_data SHALL carry data_wdata[8k+7:8k] while byte k is issued.
REQ-009 mem_vis_signal SHALL be 00 in IDLE and DONE.
REQ-010 Completion: DONE SHALL last exactly one cycle, pulse the owner's done output, and present the result on inst_data or data_rdata; the result SHALL hold until the next completion of that port.
REQ-011 Latency from the sampling edge to the done pulse SHALL be n+2 cycles for reads and n+1 cycles for writes (n = byte count); a word read SHALL therefore take 6 cycles.
REQ-012 Deasserting a request mid-transaction SHALL be ignored; the transaction SHALL complete. A request still asserted in the DONE cycle SHALL be re-arbitrated in the next IDLE cycle.
REQ-013 Request inputs SHALL be ignored outside IDLE.
REQ-014 Arbitration with both requests asserted: data SHALL win by default (see REQ-017).

Reset
REQ-015 While rst = 0 (asynchronous): state = IDLE; mem_vis_signal = 00; mem_vis_addr = 0; writen_data = 0; inst_data = 0; data_rdata = 0; inst_done = 0; data_done = 0; last-grant = inst.
REQ-016 Reset mid-transaction SHALL abort it without producing a done pulse; a partial write SHALL remain partial.

Configuration
REQ-017 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester that did not win the previous grant; after reset, data wins first. Without MEM_ARB_RR_EN, data SHALL always win and the last-grant register SHALL be omitted.

Structure
REQ-018 The state encoding, mem_vis_signal codes (IDLE/READ/WRITE) and data_size codes SHALL live in a shared package or include file that cache and cpu also include.
REQ-019 A sub-module mem_byte_seq (byte counter, address increment, byte lane steer and assemble) SHALL be instantiated once; arbitration and the FSM SHALL stay in mem_arbiter.

Verification
REQ-020 The bench SHALL cover these scenarios:
- inst_req at addr 0x00100, memory bytes 13 05 00 00 -> reads issued at 0x00100..0x00103; inst_data = 0x00000513; inst_done pulses 6 cycles after the sampling edge.
- data_req = 10, size 01, addr 0x00200, wdata 0xAABBCCDD -> two writes, DD then CC, at 0x00200 and 0x00201; data_done pulses after 3 cycles; 0x00202 is untouched.
- inst_req and data_req both asserted every IDLE cycle -> with MEM_ARB_RR_EN, grants alternate D, I, D, I; without it, inst never wins while data is held.
- Word read at 0x1FFFE -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 are issued.
- rst low during byte 2 of a word write -> mem_vis_signal = 00 immediately, no data_done, FSM in IDLE after release.
- data_req = 01, size 00, addr 0x00003, byte 0x80 -> data_rdata = 0x00000080.
